// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// Fully synchronous PS/2 keyboard receiver with an event FIFO.
//
// Receive path:
//   - Synchronises the raw keyboard clock and data lines.
//   - Debounces the keyboard clock.
//   - Checks the start, odd-parity and stop bits of each frame.
//   - Folds the E0 (extended) and F0 (break) prefixes into flags.
// Each complete key event is buffered in a first-word-fall-through FIFO.
//
// Ports:
//   clock_fpga  system clock
//   reset       asynchronous active-high reset, clears all state
//   clock_key   raw PS/2 clock (asynchronous)
//   data_key    raw PS/2 data (asynchronous)
//   rd_en       pop head event, ignored while valid=0
//   valid       FIFO holds at least one event
//   code_out    scan code of the head event, prefixes stripped
//   is_break    head event was preceded by F0
//   is_ext      head event was preceded by E0
//   fifo_count  number of events held, 0..FIFO_DEPTH
//   overflow    sticky, an event was dropped because the FIFO was full
//   parity_err  one-cycle pulse on a frame rejected for parity
//   frame_err   one-cycle pulse on a bad stop bit or an inter-bit timeout
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock_fpga,
  input  logic             reset,
  input  logic             clock_key,
  input  logic             data_key,
  input  logic             rd_en,
  output logic             valid,
  output logic [7:0]       code_out,
  output logic             is_break,
  output logic             is_ext,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             parity_err,
  output logic             frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  logic [1:0]      clk_sync;
  logic [1:0]      dat_sync;
  logic            filt_clk;
  logic [7:0]      filt_cnt;
  logic            fall_evt;
  state_t          state;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            byte_vld;
  logic [7:0]      byte_data;
  logic            ext_flag;
  logic            brk_flag;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNT_W-1:0] count;

  // Two-stage synchronisers for both keyboard lines.
  // Both idle high so a reset does not look like a start bit.
  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], clock_key};
      dat_sync <= {dat_sync[0], data_key};
    end
  end

  // Clock debounce filter.
  // The counter tracks how many consecutive samples have disagreed with the
  // filtered level. The level flips on the FILTER_LEN-th disagreeing sample.
  // A falling flip raises fall_evt for exactly one cycle.
  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_evt <= 1'b0;
    end else begin
      fall_evt <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        fall_evt <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  // Frame checker.
  // It moves only on filtered falling edges, sampling data in the same cycle.
  // An accepted byte raises byte_vld for one cycle so prefix decode can act on it.
  // The inter-bit watchdog abandons a stalled frame. It leaves the prefix
  // flags alone because those live in the decode block.
  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_vld   <= 1'b0;
      byte_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_vld   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_evt) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_sync[1]) begin
              state   <= SHIFT;
              bit_idx <= '0;
            end
          end
          SHIFT: begin
            shift_reg <= {dat_sync[1], shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= dat_sync[1];
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // A bad stop bit takes precedence over a parity failure.
            if (!dat_sync[1]) begin
              frame_err <= 1'b1;
            end else if (!(^{shift_reg, par_bit})) begin
              parity_err <= 1'b1;
            end else begin
              byte_vld  <= 1'b1;
              byte_data <= shift_reg;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt    <= '0;
        state     <= IDLE;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign push = byte_vld && (byte_data != 8'hE0) && (byte_data != 8'hF0);

  // Prefix decode.
  // E0 and F0 only set flags. Any other accepted byte is pushed together
  // with the current flags, then both flags are cleared for the next key.
  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_vld) begin
      if (byte_data == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (byte_data == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  assign valid = (count != '0);
  assign full  = (count == FULL_COUNT);
  assign pop   = rd_en && valid;
  // When the FIFO is full, a simultaneous pop frees the slot being written.
  assign wr    = push && (!full || pop);

  // Event storage. It needs no reset because the outputs are masked by valid.
  always_ff @(posedge clock_fpga) begin
    if (wr) begin
      mem[wr_ptr] <= {byte_data, brk_flag, ext_flag};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  // The pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign fifo_count = count;
  assign {code_out, is_break, is_ext} = valid ? mem[rd_ptr] : 10'd0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
// Self-checking bench for ps2_rx_fifo.
// Drives PS/2 frames bit by bit and keeps expected key events in a
// scoreboard queue, which is compared against the FIFO head as events are popped.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int FILT  = 4;
  localparam int TMO   = 200;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int HALF  = 20;

  logic             clock_fpga = 1'b0;
  logic             reset = 1'b1;
  logic             clock_key = 1'b1;
  logic             data_key = 1'b1;
  logic             rd_en = 1'b0;
  logic             valid;
  logic [7:0]       code_out;
  logic             is_break;
  logic             is_ext;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             parity_err;
  logic             frame_err;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } event_t;

  typedef struct {
    logic [7:0] code;
    bit         flip_par;
    bit         bad_stop;
    int         exp_perr;
    int         exp_ferr;
    bit         exp_push;
    bit         exp_brk;
    bit         exp_ext;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  int     perr_seen = 0;
  int     ferr_seen = 0;
  event_t sb_q[$];
  event_t head_at_pop;
  logic   valid_at_pop;

  ps2_rx_fifo #(
    .FILTER_LEN(FILT),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock_fpga(clock_fpga),
    .reset(reset),
    .clock_key(clock_key),
    .data_key(data_key),
    .rd_en(rd_en),
    .valid(valid),
    .code_out(code_out),
    .is_break(is_break),
    .is_ext(is_ext),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );

  // Free-running system clock, 20 ns period.
  always #10 clock_fpga = ~clock_fpga;

  // Count error pulses on the inactive edge so each one-cycle pulse is seen once.
  always @(negedge clock_fpga) begin
    if (parity_err) perr_seen++;
    if (frame_err) ferr_seen++;
  end

  // Hard stop in case something hangs.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation still running at 5 ms, required to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive a frame: start, 8 data bits LSB first, odd parity, stop.
  // Only the first nfalls falling clock edges are sent.
  // With pop_at_stop, rd_en is raised in the cycle where the stop bit's
  // event is being pushed.
  task automatic applyStimulus(input logic [7:0] code, input bit flip_par,
                               input bit bad_stop, input int nfalls,
                               input bit pop_at_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      @(negedge clock_fpga);
      data_key = bits[i];
      repeat (HALF) @(negedge clock_fpga);
      clock_key = 1'b0;
      if (pop_at_stop && i == 10) begin
        repeat (7) @(posedge clock_fpga);
        #1;
        head_at_pop  = {code_out, is_break, is_ext};
        valid_at_pop = valid;
        rd_en = 1'b1;
        @(posedge clock_fpga);
        #1;
        rd_en = 1'b0;
        repeat (HALF - 9) @(negedge clock_fpga);
      end else begin
        repeat (HALF) @(negedge clock_fpga);
      end
      clock_key = 1'b1;
    end
    repeat (HALF) @(negedge clock_fpga);
    data_key = 1'b1;
    repeat (HALF) @(negedge clock_fpga);
  endtask

  // Pop every expected event and compare it with the FIFO head.
  // Afterwards the FIFO must be empty.
  task automatic drainScoreboard(input string tag);
    event_t exp_ev;
    int     w;
    while (sb_q.size() > 0) begin
      exp_ev = sb_q.pop_front();
      w = 0;
      while (!valid && w < 400) begin
        @(negedge clock_fpga);
        w++;
      end
      checkOutput({tag, "_event"}, {22'd0, code_out, is_break, is_ext}, {22'd0, exp_ev});
      rd_en = 1'b1;
      @(negedge clock_fpga);
      rd_en = 1'b0;
    end
    repeat (2) @(negedge clock_fpga);
    checkOutput({tag, "_valid_empty"}, {31'd0, valid}, 32'd0);
    checkOutput({tag, "_count_empty"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    vec_t vecs[14];
    int   p0;
    int   f0;

    vecs[0]  = '{8'h1D, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h75, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h29, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h29, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h3B, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h3B, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h12, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h12, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h6B, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};

    // Reset state, sampled while reset is held.
    repeat (5) @(negedge clock_fpga);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_code", {24'd0, code_out}, 32'd0);
    checkOutput("rst_flags", {30'd0, is_break, is_ext}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_errs", {30'd0, parity_err, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock_fpga);

    // Table-driven frames: prefixes, parity errors and stop errors.
    for (int i = 0; i < 14; i++) begin
      p0 = perr_seen;
      f0 = ferr_seen;
      applyStimulus(vecs[i].code, vecs[i].flip_par, vecs[i].bad_stop, 11, 1'b0);
      if (vecs[i].exp_push) begin
        sb_q.push_back({vecs[i].code, vecs[i].exp_brk, vecs[i].exp_ext});
        checkOutput($sformatf("row%0d_count", i), 32'(fifo_count), 32'd1);
      end
      checkOutput($sformatf("row%0d_perr", i), 32'(perr_seen - p0), 32'(vecs[i].exp_perr));
      checkOutput($sformatf("row%0d_ferr", i), 32'(ferr_seen - f0), 32'(vecs[i].exp_ferr));
      drainScoreboard($sformatf("row%0d", i));
    end

    // A frame that stalls after 4 falls must time out.
    f0 = ferr_seen;
    applyStimulus(8'h76, 1'b0, 1'b0, 4, 1'b0);
    repeat (3 * TMO) @(negedge clock_fpga);
    checkOutput("timeout_ferr", 32'(ferr_seen - f0), 32'd1);
    checkOutput("timeout_valid", {31'd0, valid}, 32'd0);
    applyStimulus(8'h76, 1'b0, 1'b0, 11, 1'b0);
    sb_q.push_back({8'h76, 1'b0, 1'b0});
    checkOutput("after_timeout_ferr", 32'(ferr_seen - f0), 32'd1);
    drainScoreboard("timeout");

    // A glitch of FILTER_LEN-1 low cycles with data low must not start a frame.
    // If it did, the frame would later time out.
    p0 = perr_seen;
    f0 = ferr_seen;
    @(negedge clock_fpga);
    data_key = 1'b0;
    clock_key = 1'b0;
    repeat (FILT - 1) @(negedge clock_fpga);
    clock_key = 1'b1;
    repeat (3 * TMO) @(negedge clock_fpga);
    data_key = 1'b1;
    checkOutput("glitch_ferr", 32'(ferr_seen - f0), 32'd0);
    checkOutput("glitch_valid", {31'd0, valid}, 32'd0);
    applyStimulus(8'h5A, 1'b0, 1'b0, 11, 1'b0);
    sb_q.push_back({8'h5A, 1'b0, 1'b0});
    checkOutput("glitch_errs", 32'(ferr_seen - f0 + perr_seen - p0), 32'd0);
    drainScoreboard("glitch");

    // rd_en on an empty FIFO is ignored.
    @(negedge clock_fpga);
    rd_en = 1'b1;
    @(negedge clock_fpga);
    rd_en = 1'b0;
    @(negedge clock_fpga);
    checkOutput("empty_rd_count", 32'(fifo_count), 32'd0);

    // Push coinciding with rd_en on an empty FIFO still lands.
    applyStimulus(8'h4D, 1'b0, 1'b0, 11, 1'b1);
    sb_q.push_back({8'h4D, 1'b0, 1'b0});
    checkOutput("empty_push_rd_valid_at", {31'd0, valid_at_pop}, 32'd0);
    checkOutput("empty_push_rd_count", 32'(fifo_count), 32'd1);
    drainScoreboard("empty_push_rd");

    // Nine codes without reading: the ninth is dropped and overflow sticks.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(8'(k), 1'b0, 1'b0, 11, 1'b0);
      if (k <= DEPTH) sb_q.push_back({8'(k), 1'b0, 1'b0});
    end
    checkOutput("full_count", 32'(fifo_count), 32'(DEPTH));
    checkOutput("full_overflow", {31'd0, overflow}, 32'd1);

    // Push and pop together at full: nothing lost, count unchanged.
    applyStimulus(8'h0A, 1'b0, 1'b0, 11, 1'b1);
    checkOutput("coincident_head", {22'd0, head_at_pop}, {22'd0, sb_q[0]});
    void'(sb_q.pop_front());
    sb_q.push_back({8'h0A, 1'b0, 1'b0});
    checkOutput("coincident_count", 32'(fifo_count), 32'(DEPTH));
    drainScoreboard("overflow");
    checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-frame, with a stored event and a pending break prefix.
    applyStimulus(8'h33, 1'b0, 1'b0, 11, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 11, 1'b0);
    applyStimulus(8'h21, 1'b0, 1'b0, 5, 1'b0);
    @(negedge clock_fpga);
    reset = 1'b1;
    repeat (3) @(negedge clock_fpga);
    checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
    checkOutput("midrst_count", 32'(fifo_count), 32'd0);
    checkOutput("midrst_code", {24'd0, code_out}, 32'd0);
    checkOutput("midrst_flags", {30'd0, is_break, is_ext}, 32'd0);
    checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    sb_q.delete();
    repeat (5) @(negedge clock_fpga);
    p0 = perr_seen;
    f0 = ferr_seen;
    applyStimulus(8'h44, 1'b0, 1'b0, 11, 1'b0);
    sb_q.push_back({8'h44, 1'b0, 1'b0});
    checkOutput("postrst_errs", 32'(ferr_seen - f0 + perr_seen - p0), 32'd0);
    drainScoreboard("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
